// File: rtl/mem_arb.sv
// Arbitrates one single-ported memory between instruction fetch (IFU) and load/store (LSU).
// Define MEM_ARB_RR_EN to switch conflict resolution from fixed LSU priority to round-robin.
module mem_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_ifu_req_valid,
    output logic                    o_ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ifu_req_addr,
    output logic                    o_ifu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_ifu_rsp_data,
    input  logic                    i_lsu_req_valid,
    output logic                    o_lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_lsu_req_addr,
    input  logic                    i_lsu_req_wr_en,
    input  logic [DATA_WIDTH-1:0]   i_lsu_req_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_lsu_req_wr_mask,
    output logic                    o_lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_lsu_rsp_data,
    output logic                    o_ram_req_valid,
    input  logic                    i_ram_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_ram_req_addr,
    output logic                    o_ram_req_wr_en,
    output logic [DATA_WIDTH-1:0]   o_ram_req_wr_data,
    output logic [DATA_WIDTH/8-1:0] o_ram_req_wr_mask,
    input  logic                    i_ram_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_ram_rsp_data,
    output logic                    o_arb_err
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;   // 1 = LSU owns the transaction
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [MW-1:0]         mask_q, mask_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  lsu_prio, gnt_lsu, gnt_ifu;

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;   // 1 = LSU was granted last
    assign lsu_prio = ~last_q;
`else
    assign lsu_prio = 1'b1;
`endif

    assign gnt_lsu = i_lsu_req_valid & (~i_ifu_req_valid | lsu_prio);
    assign gnt_ifu = i_ifu_req_valid & ~gnt_lsu;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        wr_en_d         = wr_en_q;
        wdata_d         = wdata_q;
        mask_d          = mask_q;
        rdata_d         = rdata_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
`ifdef MEM_ARB_RR_EN
        last_d          = last_q;
`endif
        o_ifu_req_ready = 1'b0;
        o_lsu_req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                o_ifu_req_ready = gnt_ifu;
                o_lsu_req_ready = gnt_lsu;
                if (gnt_lsu) begin
                    owner_d = 1'b1;
                    addr_d  = i_lsu_req_addr;
                    wr_en_d = i_lsu_req_wr_en;
                    wdata_d = i_lsu_req_wr_data;
                    mask_d  = i_lsu_req_wr_mask;
                    rdata_d = '0;
                    state_d = REQ;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b1;
`endif
                end else if (gnt_ifu) begin
                    owner_d = 1'b0;
                    addr_d  = i_ifu_req_addr;
                    wr_en_d = 1'b0;
                    wdata_d = '0;
                    mask_d  = '0;
                    rdata_d = '0;
                    state_d = REQ;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b0;
`endif
                end
            end
            REQ: begin
                if (i_ram_req_ready) begin
                    if (wr_en_q) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A response arriving on the timeout cycle still counts as good.
                if (i_ram_rsp_valid) begin
                    rdata_d = i_ram_rsp_data;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            addr_q  <= '0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            mask_q  <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign o_ram_req_valid   = (state_q == REQ);
    assign o_ram_req_addr    = addr_q;
    assign o_ram_req_wr_en   = wr_en_q;
    assign o_ram_req_wr_data = wdata_q;
    assign o_ram_req_wr_mask = mask_q;
    assign o_ifu_rsp_valid   = (state_q == RESP) & ~owner_q;
    assign o_lsu_rsp_valid   = (state_q == RESP) & owner_q;
    assign o_ifu_rsp_data    = o_ifu_rsp_valid ? rdata_q : '0;
    assign o_lsu_rsp_data    = o_lsu_rsp_valid ? rdata_q : '0;
    assign o_arb_err         = err_q;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: expected responses queued as memory stimulus is chosen,
// popped by a response monitor.
module tb_mem_arb;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_v, ifu_rdy, ifu_rv;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rd;
    logic          lsu_v, lsu_rdy, lsu_we, lsu_rv;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wd, lsu_rd;
    logic [MW-1:0] lsu_wm;
    logic          ram_v, ram_rdy, ram_we, ram_rv;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wd, ram_rd;
    logic [MW-1:0] ram_wm;
    logic          err;

    typedef struct {
        bit            lsu;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .i_sys_clk        (clk),
        .i_sys_rst        (rst),
        .i_ifu_req_valid  (ifu_v),
        .o_ifu_req_ready  (ifu_rdy),
        .i_ifu_req_addr   (ifu_addr),
        .o_ifu_rsp_valid  (ifu_rv),
        .o_ifu_rsp_data   (ifu_rd),
        .i_lsu_req_valid  (lsu_v),
        .o_lsu_req_ready  (lsu_rdy),
        .i_lsu_req_addr   (lsu_addr),
        .i_lsu_req_wr_en  (lsu_we),
        .i_lsu_req_wr_data(lsu_wd),
        .i_lsu_req_wr_mask(lsu_wm),
        .o_lsu_rsp_valid  (lsu_rv),
        .o_lsu_rsp_data   (lsu_rd),
        .o_ram_req_valid  (ram_v),
        .i_ram_req_ready  (ram_rdy),
        .o_ram_req_addr   (ram_addr),
        .o_ram_req_wr_en  (ram_we),
        .o_ram_req_wr_data(ram_wd),
        .o_ram_req_wr_mask(ram_wm),
        .i_ram_rsp_valid  (ram_rv),
        .i_ram_rsp_data   (ram_rd),
        .o_arb_err        (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester valids/fields are already driven; check the grant and take the handshake edge.
    task automatic accept(input bit exp_lsu);
        #1;
        chk("ifu_ready", ifu_rdy, !exp_lsu);
        chk("lsu_ready", lsu_rdy, exp_lsu);
        tick();
    endtask

    // Called in the first REQ cycle; plays the memory and expects the owner's response.
    // rsp_dly = number of silent WAIT cycles before the response, -1 = never respond.
    task automatic serve(input bit exp_lsu, input logic [AW-1:0] e_addr, input bit e_we,
                         input logic [DW-1:0] e_wd, input logic [MW-1:0] e_wm,
                         input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rdata);
        exp_t e;
        e.lsu  = exp_lsu;
        e.data = e_we ? '0 : ((rsp_dly >= 0 && rsp_dly < TO) ? rdata : '1);
        exp_q.push_back(e);
        for (int i = 0; i <= rdy_dly; i++) begin
            ram_rdy = (i == rdy_dly);
            #1;
            chk("req_valid", ram_v, 1);
            chk("req_addr", ram_addr, e_addr);
            chk("req_we", ram_we, e_we);
            chk("req_wd", ram_wd, e_wd);
            chk("req_wm", ram_wm, e_wm);
            chk("rdy_busy", {ifu_rdy, lsu_rdy}, 0);
            tick();
        end
        ram_rdy = 1'b0;
        if (!e_we) begin
            for (int i = 0; i < TO; i++) begin
                chk("wait_rsp_quiet", {ifu_rv, lsu_rv}, 0);
                if (i == rsp_dly) begin
                    ram_rv = 1'b1;
                    ram_rd = rdata;
                end
                tick();
                ram_rv = 1'b0;
                if (i == rsp_dly) break;
            end
        end
        chk("rsp_ifu_v", ifu_rv, !exp_lsu);
        chk("rsp_lsu_v", lsu_rv, exp_lsu);
        tick();
        chk("rsp_one_cycle", {ifu_rv, lsu_rv}, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ifu_rv || lsu_rv) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {ifu_rv, lsu_rv}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_owner", lsu_rv, e.lsu);
                chk("rsp_data", e.lsu ? lsu_rd : ifu_rd, e.data);
            end
        end
    end

    initial begin
        bit exp2;
        rst = 1'b1;
        ifu_v = 0; ifu_addr = '0;
        lsu_v = 0; lsu_addr = '0; lsu_we = 0; lsu_wd = '0; lsu_wm = '0;
        ram_rdy = 0; ram_rv = 0; ram_rd = '0;
        repeat (3) tick();
        chk("rst_ram_v", ram_v, 0);
        chk("rst_fields", {ram_addr, ram_we, ram_wm}, 0);
        chk("rst_rsp", {ifu_rv, lsu_rv, ifu_rdy, lsu_rdy, err}, 0);
        rst = 1'b0;
        tick();

        // Conflict: both requesters valid for two back-to-back transactions.
        ifu_v = 1; ifu_addr = 32'h8000_0040;
        lsu_v = 1; lsu_addr = 32'h0000_0100; lsu_we = 0; lsu_wd = 32'h1111_2222; lsu_wm = 4'hF;
        accept(1);
        serve(1, 32'h0000_0100, 0, 32'h1111_2222, 4'hF, 0, 0, 32'hA5A5_0001);
`ifdef MEM_ARB_RR_EN
        exp2 = 0;
`else
        exp2 = 1;
`endif
        accept(exp2);
        ifu_v = 0; lsu_v = 0;
        if (exp2) serve(1, 32'h0000_0100, 0, 32'h1111_2222, 4'hF, 0, 1, 32'hA5A5_0002);
        else      serve(0, 32'h8000_0040, 0, '0, '0, 0, 1, 32'hA5A5_0002);

        // IFU load, zero-wait memory: response at N+3.
        ifu_v = 1; ifu_addr = 32'h8000_0000;
        accept(0);
        ifu_v = 0;
        serve(0, 32'h8000_0000, 0, '0, '0, 0, 0, 32'h0000_0013);

        // LSU store with ready held low for 3 cycles.
        lsu_v = 1; lsu_addr = 32'h8000_1000; lsu_we = 1; lsu_wd = 32'hDEAD_BEEF; lsu_wm = 4'b0011;
        accept(1);
        lsu_v = 0;
        serve(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 3, 0, 32'h5555_5555);

        // Response on the timeout cycle wins; no error.
        lsu_we = 0; lsu_addr = 32'h0000_0300; lsu_v = 1;
        accept(1);
        lsu_v = 0;
        serve(1, 32'h0000_0300, 0, 32'hDEAD_BEEF, 4'b0011, 1, TO - 1, 32'h0BAD_F00D);
        chk("err_coincide", err, 0);

        // Memory never responds: all-ones data and sticky error.
        lsu_addr = 32'h0000_0200; lsu_v = 1;
        accept(1);
        lsu_v = 0;
        serve(1, 32'h0000_0200, 0, 32'hDEAD_BEEF, 4'b0011, 0, -1, '0);
        chk("err_timeout", err, 1);
        ifu_v = 1; ifu_addr = 32'h8000_0004;
        accept(0);
        ifu_v = 0;
        serve(0, 32'h8000_0004, 0, '0, '0, 0, 2, 32'h1234_5678);
        chk("err_sticky", err, 1);

        // Reset while in WAIT drops the transaction.
        lsu_addr = 32'h0000_0400; lsu_v = 1;
        accept(1);
        lsu_v = 0;
        ram_rdy = 1;
        tick();
        ram_rdy = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_ram_v", ram_v, 0);
        chk("mid_rst_fields", {ram_addr, ram_we, ram_wd, ram_wm}, 0);
        chk("mid_rst_rsp", {ifu_rv, lsu_rv, ifu_rd, lsu_rd}, 0);
        chk("mid_rst_err", err, 0);
        ram_rv = 1; ram_rd = 32'hFACE_FACE;
        tick();
        chk("late_rsp_ignored", {ifu_rv, lsu_rv, ram_v}, 0);

        // Stray response in IDLE (still driven), then a normal fetch is granted at once.
        tick();
        chk("stray_rsp_ignored", {ifu_rv, lsu_rv, ram_v}, 0);
        ram_rv = 0;
        ifu_v = 1; ifu_addr = 32'h8000_0008;
        accept(0);
        ifu_v = 0;
        serve(0, 32'h8000_0008, 0, '0, '0, 0, 0, 32'h0000_0093);
        chk("err_after_rst", err, 0);

        repeat (2) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
